spi_reg_bank: RTL

//  SPI mode-0 peripheral (target) feeding the PWM peripheral its configuration registers.

---
 rtl/spi_reg_bank_if.sv | 22 ++
 rtl/spi_reg_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an SPI controller and the spi_reg_bank target.
// The master modport is the controller side; the slave modport is the register bank.
interface spi_reg_bank_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (
    output sclk,
    output copi,
    output ncs,
    input  cipo
  );

  modport slave (
    input  sclk,
    input  copi,
    input  ncs,
    output cipo
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target that decodes 16-bit write frames into the PWM configuration registers.
// Optional register readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5,
  parameter int FRAME_BITS  = 16
) (
  input  logic           clk,
  input  logic           rst,
  spi_reg_bank_if.slave  spi,
  output logic [7:0]     o_en_reg_out_7_0,
  output logic [7:0]     o_en_reg_out_15_8,
  output logic [7:0]     o_en_reg_pwm_7_0,
  output logic [7:0]     o_en_reg_pwm_15_8,
  output logic [7:0]     o_pwm_duty_cycle,
  output logic           o_frame_err
);

  localparam int ADDR_W    = FRAME_BITS - 9;
  localparam int CNT_W     = $clog2(FRAME_BITS + 2);
  localparam int REG_SLOTS = (NUM_REGS > 5) ? NUM_REGS : 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sclk_sync;
  logic [SYNC_STAGES-1:0]  r_copi_sync;
  logic [SYNC_STAGES-1:0]  r_ncs_sync;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [7:0]              r_regs [REG_SLOTS];
  logic                    r_frame_err;

  logic                    w_sclk_rise;
  logic                    w_ncs_rise;
  logic                    w_ncs_fall;
  logic                    w_copi;
  logic                    w_start;
  logic                    w_shift_en;
  logic                    w_wr_en;
  logic                    w_err;
  logic                    w_is_write;
  logic [ADDR_W-1:0]       w_addr;
  logic [7:0]              w_data;
  logic                    w_addr_ok;

  // Synchronisers are deliberately left out of reset: a chip select held low
  // across reset release must not look like a fresh falling edge.
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
    r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
    r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0],  spi.ncs};
  end

  // Edge detection on the last two synchroniser stages
  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_rise  = r_ncs_sync[SYNC_STAGES-2]  & ~r_ncs_sync[SYNC_STAGES-1];
  assign w_ncs_fall  = ~r_ncs_sync[SYNC_STAGES-2] &  r_ncs_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];

  assign w_is_write = r_shift[FRAME_BITS-1];
  assign w_addr     = r_shift[FRAME_BITS-2:8];
  assign w_data     = r_shift[7:0];
  assign w_addr_ok  = int'(w_addr) < NUM_REGS;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A chip-select rise outranks a coincident sclk rise, so the edge is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_wr_en     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_ncs_rise) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_sclk_rise) begin
          w_shift_en = 1'b1;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
          w_wr_en = w_is_write & w_addr_ok;
        end else begin
          w_err = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_start) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
      if (r_bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_SLOTS; i++) begin
        r_regs[i] <= 8'h00;
      end
      r_frame_err <= 1'b0;
    end else begin
      for (int i = 0; i < REG_SLOTS; i++) begin
        if (w_wr_en && int'(w_addr) == i) begin
          r_regs[i] <= w_data;
        end
      end
      r_frame_err <= w_err;
    end
  end

  assign o_en_reg_out_7_0  = r_regs[0];
  assign o_en_reg_out_15_8 = r_regs[1];
  assign o_en_reg_pwm_7_0  = r_regs[2];
  assign o_en_reg_pwm_15_8 = r_regs[3];
  assign o_pwm_duty_cycle  = r_regs[4];
  assign o_frame_err       = r_frame_err;

`ifdef SPI_READBACK_EN
  logic                  w_sclk_fall;
  logic [FRAME_BITS-9:0] w_hdr;
  logic [7:0]            w_rd_val;
  logic [7:0]            r_rd_data;
  logic                  r_cipo;

  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
  // Header as it will look once the current sclk rise has been shifted in
  assign w_hdr       = {r_shift[FRAME_BITS-10:0], w_copi};

  always_comb begin
    w_rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_hdr[ADDR_W-1:0]) == i) begin
        w_rd_val = r_regs[i];
      end
    end
  end

  // Read data is loaded on the last header bit and presented on each following sclk fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= 8'h00;
      r_cipo    <= 1'b0;
    end else if (r_state != ST_SHIFT || w_ncs_rise) begin
      r_rd_data <= 8'h00;
      r_cipo    <= 1'b0;
    end else if (w_shift_en && r_bit_cnt == CNT_W'(FRAME_BITS - 9)) begin
      r_rd_data <= w_hdr[FRAME_BITS-9] ? 8'h00 : w_rd_val;
    end else if (w_sclk_fall) begin
      r_cipo    <= r_rd_data[7];
      r_rd_data <= {r_rd_data[6:0], 1'b0};
    end
  end

  assign spi.cipo = r_cipo;
`else
  assign spi.cipo = 1'b0;
`endif

endmodule
